// File: rtl/acc_frame_sum_if.sv
// acc_frame_sum_if
// Handshake and result bundle for the accumulator front end.
//   start     - one-cycle frame request (master -> slave)
//   in_valid  - sample valid (master -> slave)
//   in_data   - unsigned sample, WIDTH bits (master -> slave)
//   in_ready  - slave can take a sample this cycle (slave -> master)
//   sum       - running / final frame sum, WIDTH bits (slave -> master)
//   busy      - frame in progress (slave -> master)
//   done      - one-cycle pulse, sum is final (slave -> master)
//   overflow  - sticky per-frame carry-out flag (slave -> master)
interface acc_frame_sum_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, sum, busy, done, overflow
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, sum, busy, done, overflow
  );
endinterface

// File: rtl/acc_frame_sum.sv
// acc_frame_sum
// Accepts a frame of COUNT unsigned samples over a valid/ready handshake and
// sums them. The final sum is held from DONE until the next accepted start so
// the downstream output register can capture it on the done pulse.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous, active-low reset
//   bus    - acc_frame_sum_if slave modport (start, in_valid, in_data in;
//            in_ready, sum, busy, done, overflow out)
// Parameters:
//   WIDTH  - sample and sum width
//   COUNT  - samples per frame, 1..255
// Compile-time option:
//   ACC_SATURATE_EN - when defined the sum clamps to all-ones on carry-out;
//                     otherwise the sum wraps modulo 2^WIDTH.
module acc_frame_sum #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  acc_frame_sum_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(COUNT - 1);

  state_t           state_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [7:0]       cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   add_s;
  logic             carry_s;
  logic             accept_s;
  logic             last_s;

  // Extra top bit of the adder catches the carry-out.
  assign add_s    = {1'b0, sum_q} + {1'b0, bus.in_data};
  assign carry_s  = add_s[WIDTH];
  assign accept_s = bus.in_valid & in_ready_q;
  assign last_s   = (cnt_q == CNT_LAST);

  // Next sum value for an accepted beat: saturating or wrapping add.
  always_comb begin
    sum_d = add_s[WIDTH-1:0];
`ifdef ACC_SATURATE_EN
    if (carry_s) begin
      sum_d = {WIDTH{1'b1}};
    end else begin
      sum_d = add_s[WIDTH-1:0];
    end
`else
    sum_d = add_s[WIDTH-1:0];
`endif
  end

  // Frame FSM; handshake/status flags are registered alongside the state
  // so they carry no combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sum_q      <= {WIDTH{1'b0}};
      cnt_q      <= 8'd0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q    <= S_ACCUM;
            sum_q      <= {WIDTH{1'b0}};
            cnt_q      <= 8'd0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (accept_s) begin
            sum_q <= sum_d;
            cnt_q <= cnt_q + 8'd1;
            ovf_q <= ovf_q | carry_s;
            if (last_s) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end else begin
            state_q <= S_ACCUM;
          end
        end
        S_DONE: begin
          // Sum and overflow stay put; only the done pulse ends here.
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_acc_frame_sum.sv
// tb_acc_frame_sum
// Directed bench for acc_frame_sum with WIDTH=8, COUNT=4. Inputs change 1 ns
// after each rising edge; outputs are read at that same point, well away from
// the next active edge. Honours ACC_SATURATE_EN for the overflow frame.
module tb_acc_frame_sum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  acc_frame_sum_if #(.WIDTH(8)) bus ();

  acc_frame_sum #(.WIDTH(8), .COUNT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (bus.sum !== 8'h00 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
        errs++;
        $display("FAIL reset_idle cyc=%0d got sum=%h rdy=%b busy=%b done=%b ovf=%b exp 00 0 0 0 0",
                 i, bus.sum, bus.in_ready, bus.busy, bus.done, bus.overflow);
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic test_basic();
    do_start();
    vecs++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL basic_accum got busy=%b rdy=%b exp 1 1", bus.busy, bus.in_ready);
    end
    for (int i = 1; i <= 3; i++) begin
      beat(8'(i));
      vecs++;
      if (bus.done !== 1'b0) begin
        errs++;
        $display("FAIL basic_early_done beat=%0d got done=%b exp 0", i, bus.done);
      end
    end
    vecs++;
    if (bus.sum !== 8'd6) begin
      errs++;
      $display("FAIL basic_partial got sum=%0d exp 6", bus.sum);
    end
    beat(8'd4);
    vecs++;
    if (bus.done !== 1'b1 || bus.sum !== 8'd10 || bus.overflow !== 1'b0 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL basic_done got done=%b sum=%0d ovf=%b rdy=%b exp 1 10 0 0",
               bus.done, bus.sum, bus.overflow, bus.in_ready);
    end
    step();
    vecs++;
    if (bus.done !== 1'b0) begin
      errs++;
      $display("FAIL basic_done_pulse got done=%b exp 0", bus.done);
    end
    step();
    step();
    vecs++;
    if (bus.sum !== 8'd10 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_hold got sum=%0d busy=%b exp 10 0", bus.sum, bus.busy);
    end
  endtask

  task automatic test_stalls();
    do_start();
    for (int i = 1; i <= 4; i++) begin
      for (int s = 0; s < 3; s++) begin
        step();
        vecs++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          errs++;
          $display("FAIL stall_wait beat=%0d got done=%b busy=%b exp 0 1", i, bus.done, bus.busy);
        end
      end
      beat(8'(i));
    end
    vecs++;
    if (bus.done !== 1'b1 || bus.sum !== 8'd10) begin
      errs++;
      $display("FAIL stall_done got done=%b sum=%0d exp 1 10", bus.done, bus.sum);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_sum;
`ifdef ACC_SATURATE_EN
    exp_sum = 8'hFF;
`else
    exp_sum = 8'h01;
`endif
    step();
    do_start();
    beat(8'hFF);
    beat(8'h02);
    beat(8'h00);
    beat(8'h00);
    vecs++;
    if (bus.done !== 1'b1 || bus.sum !== exp_sum || bus.overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_frame got done=%b sum=%h ovf=%b exp 1 %h 1",
               bus.done, bus.sum, bus.overflow, exp_sum);
    end
    step();
    step();
    vecs++;
    if (bus.overflow !== 1'b1 || bus.sum !== exp_sum) begin
      errs++;
      $display("FAIL ovf_sticky got ovf=%b sum=%h exp 1 %h", bus.overflow, bus.sum, exp_sum);
    end
    do_start();
    vecs++;
    if (bus.overflow !== 1'b0 || bus.sum !== 8'h00) begin
      errs++;
      $display("FAIL ovf_clear got ovf=%b sum=%h exp 0 00", bus.overflow, bus.sum);
    end
    for (int i = 0; i < 4; i++) beat(8'h10);
    vecs++;
    if (bus.done !== 1'b1 || bus.sum !== 8'h40 || bus.overflow !== 1'b0) begin
      errs++;
      $display("FAIL ovf_next_frame got done=%b sum=%h ovf=%b exp 1 40 0",
               bus.done, bus.sum, bus.overflow);
    end
  endtask

  task automatic test_reset_mid();
    step();
    do_start();
    beat(8'd7);
    beat(8'd8);
    vecs++;
    if (bus.sum !== 8'd15) begin
      errs++;
      $display("FAIL rmid_partial got sum=%0d exp 15", bus.sum);
    end
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (bus.sum !== 8'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
        errs++;
        $display("FAIL rmid_abort cyc=%0d got sum=%0d busy=%b rdy=%b done=%b exp 0 0 0 0",
                 i, bus.sum, bus.busy, bus.in_ready, bus.done);
      end
      step();
    end
    bus.in_valid = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) beat(8'd5);
    vecs++;
    if (bus.done !== 1'b1 || bus.sum !== 8'd20) begin
      errs++;
      $display("FAIL rmid_refill got done=%b sum=%0d exp 1 20", bus.done, bus.sum);
    end
  endtask

  task automatic test_ignored_start();
    step();
    do_start();
    beat(8'd1);
    bus.start = 1'b1;
    beat(8'd2);
    bus.start = 1'b0;
    vecs++;
    if (bus.sum !== 8'd3 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL ign_accum got sum=%0d busy=%b exp 3 1", bus.sum, bus.busy);
    end
    beat(8'd3);
    beat(8'd4);
    vecs++;
    if (bus.done !== 1'b1 || bus.sum !== 8'd10) begin
      errs++;
      $display("FAIL ign_done got done=%b sum=%0d exp 1 10", bus.done, bus.sum);
    end
    do_start();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.sum !== 8'd10) begin
        errs++;
        $display("FAIL ign_in_done cyc=%0d got busy=%b rdy=%b sum=%0d exp 0 0 10",
                 i, bus.busy, bus.in_ready, bus.sum);
      end
      step();
    end
    bus.in_valid = 1'b0;
    do_start();
    vecs++;
    if (bus.busy !== 1'b1 || bus.sum !== 8'd0) begin
      errs++;
      $display("FAIL ign_real_start got busy=%b sum=%0d exp 1 0", bus.busy, bus.sum);
    end
    for (int i = 0; i < 4; i++) beat(8'd2);
  endtask

  task automatic test_back_to_back();
    // Entered on the DONE cycle of the previous frame; start in first IDLE.
    int cyc;
    vecs++;
    if (bus.done !== 1'b1 || bus.sum !== 8'd8) begin
      errs++;
      $display("FAIL b2b_prev got done=%b sum=%0d exp 1 8", bus.done, bus.sum);
    end
    step();
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd3;
    cyc = 0;
    step();
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    vecs++;
    if (cyc !== 4 || bus.sum !== 8'd12) begin
      errs++;
      $display("FAIL b2b_latency got cycles=%0d sum=%0d exp 4 12", cyc, bus.sum);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_stalls();
    test_overflow();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
